// File: rtl/sort_mem_bridge.sv
// Memory-side responder for the sort engine: each engine beat becomes one
// single-word SRAM transaction, answered with a one-cycle ready pulse.
module sort_mem_bridge #(
  parameter int ADDR_SHIFT = 3,
  parameter int MEM_AW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_enable,
  input  logic [63:0]       read_addr,
  input  logic              finish_read,
  output logic [63:0]       read_ready,
  output logic [63:0]       read_data,
  input  logic              write_enable,
  input  logic [63:0]       write_addr,
  input  logic [63:0]       write_data,
  input  logic              finish_write,
  output logic [63:0]       write_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              proto_err,
  output logic [31:0]       rd_beats,
  output logic [31:0]       wr_beats
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic              r_rdEnQ;
  logic              r_wrEnQ;
  logic              r_rdPend;
  logic              r_wrPend;
  logic [MEM_AW-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_readData;
  logic              r_protoErr;
  logic [31:0]       r_rdBeats;
  logic [31:0]       r_wrBeats;

  logic              w_rdBusy;
  logic              w_wrBusy;
  logic              w_rdFinErr;
  logic              w_wrFinErr;
  logic              w_rdSet;
  logic              w_wrSet;
  logic              w_rdWant;
  logic              w_wrWant;
  logic              w_rdTake;
  logic              w_wrTake;
  logic              w_rdPulse;
  logic              w_wrPulse;
  logic              w_bothEn;
  logic [MEM_AW-1:0] w_rdWordAddr;
  logic [MEM_AW-1:0] w_wrWordAddr;

  assign w_rdBusy   = (r_state == RD_REQ) || (r_state == RD_WAIT);
  assign w_wrBusy   = (r_state == WR_REQ);
  assign w_rdFinErr = finish_read  & (r_rdPend | w_rdBusy);
  assign w_wrFinErr = finish_write & (r_wrPend | w_wrBusy);
  assign w_bothEn   = read_enable & write_enable;

  // A trigger in the IDLE cycle is served immediately, so the request
  // appears one cycle after the enable rise or finish pulse.
  assign w_rdSet  = (read_enable & ~r_rdEnQ) | (finish_read & read_enable & ~w_rdFinErr);
  assign w_wrSet  = (write_enable & ~r_wrEnQ) | (finish_write & write_enable & ~w_wrFinErr);
  assign w_rdWant = r_rdPend | w_rdSet;
  assign w_wrWant = r_wrPend | w_wrSet;
  assign w_rdTake = (r_state == IDLE) & w_rdWant;
  assign w_wrTake = (r_state == IDLE) & ~w_rdWant & w_wrWant;

  assign w_rdWordAddr = MEM_AW'(read_addr >> ADDR_SHIFT);
  assign w_wrWordAddr = MEM_AW'(write_addr >> ADDR_SHIFT);

  assign w_rdPulse = (r_state == RD_RESP) & read_enable;
  assign w_wrPulse = (r_state == WR_RESP) & write_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_rdTake) begin
          w_nextState = RD_REQ;
        end else if (w_wrTake) begin
          w_nextState = WR_REQ;
        end
      end
      RD_REQ:  if (mem_gnt) w_nextState = RD_WAIT;
      RD_WAIT: if (mem_rvalid) w_nextState = RD_RESP;
      RD_RESP: w_nextState = IDLE;
      WR_REQ:  if (mem_gnt) w_nextState = WR_RESP;
      WR_RESP: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    read_ready    = '0;
    write_ready   = '0;
    read_ready[0] = w_rdPulse;
    write_ready[0] = w_wrPulse;
    mem_req   = (r_state == RD_REQ) || (r_state == WR_REQ);
    mem_we    = (r_state == WR_REQ);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_addr = r_addr;
    end
    if (mem_we) begin
      mem_wdata = r_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdEnQ  <= 1'b0;
      r_wrEnQ  <= 1'b0;
      r_rdPend <= 1'b0;
      r_wrPend <= 1'b0;
    end else begin
      r_rdEnQ  <= read_enable;
      r_wrEnQ  <= write_enable;
      r_rdPend <= w_rdWant & ~w_rdTake;
      r_wrPend <= w_wrWant & ~w_wrTake;
    end
  end

  // One shared address/data latch is enough: only one transaction is ever in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_readData <= '0;
    end else begin
      if (w_rdTake) begin
        r_addr <= w_rdWordAddr;
      end else if (w_wrTake) begin
        r_addr  <= w_wrWordAddr;
        r_wdata <= write_data;
      end
      if ((r_state == RD_WAIT) && mem_rvalid) begin
        r_readData <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_protoErr <= 1'b0;
      r_rdBeats  <= '0;
      r_wrBeats  <= '0;
    end else begin
      if (w_rdFinErr || w_wrFinErr || w_bothEn) begin
        r_protoErr <= 1'b1;
      end
      if (w_rdPulse) begin
        r_rdBeats <= r_rdBeats + 32'd1;
      end
      if (w_wrPulse) begin
        r_wrBeats <= r_wrBeats + 32'd1;
      end
    end
  end

  assign read_data = r_readData;
  assign proto_err = r_protoErr;
  assign rd_beats  = r_rdBeats;
  assign wr_beats  = r_wrBeats;

endmodule

// File: tb/tb_sort_mem_bridge.sv
// Scoreboard bench for sort_mem_bridge: stimulus pushes expected responses,
// a negedge monitor pops them whenever the bridge answers or issues a request.
module tb_sort_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_enable;
  logic [63:0] read_addr;
  logic        finish_read;
  logic [63:0] read_ready;
  logic [63:0] read_data;
  logic        write_enable;
  logic [63:0] write_addr;
  logic [63:0] write_data;
  logic        finish_write;
  logic [63:0] write_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        proto_err;
  logic [31:0] rd_beats;
  logic [31:0] wr_beats;

  typedef struct packed {
    logic [63:0] data;
    int          expCyc;
  } rdExp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
  } reqExp_t;

  rdExp_t  rdExpQ[$];
  int      wrExpQ[$];
  reqExp_t reqExpQ[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdSeen   = 0;
  int wrSeen   = 0;
  int stallCnt = 0;

  logic        gntBlock = 1'b0;
  int          rvLat    = 1;
  logic [63:0] memArr [0:255];

  localparam logic [63:0] WORD_A = 64'hA5A5_0000_1111_000A;
  localparam logic [63:0] WORD_B = 64'hB6B6_0000_2222_000B;
  localparam logic [63:0] WORD_C = 64'hC7C7_0000_3333_000C;
  localparam logic [63:0] WORD_D = 64'hD8D8_0000_4444_000D;
  localparam logic [63:0] WORD_E = 64'hE9E9_0000_5555_000E;

  sort_mem_bridge #(.ADDR_SHIFT(3), .MEM_AW(16)) dut (
    .clk(clk),
    .reset(reset),
    .read_enable(read_enable),
    .read_addr(read_addr),
    .finish_read(finish_read),
    .read_ready(read_ready),
    .read_data(read_data),
    .write_enable(write_enable),
    .write_addr(write_addr),
    .write_data(write_data),
    .finish_write(finish_write),
    .write_ready(write_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .proto_err(proto_err),
    .rd_beats(rd_beats),
    .wr_beats(wr_beats)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_gnt = mem_req & ~gntBlock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model: writes land on grant, read data returns rvLat cycles after grant.
  initial begin
    int          rvCnt;
    logic [63:0] rdBuf;
    for (int i = 0; i < 256; i++) memArr[i] = 64'd0;
    memArr[8'h20] = WORD_A;
    memArr[8'h21] = WORD_B;
    memArr[8'h22] = WORD_C;
    memArr[8'h23] = WORD_D;
    memArr[8'h24] = WORD_E;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    rvCnt = 0;
    rdBuf = 64'd0;
    forever begin
      @(posedge clk);
      mem_rvalid <= 1'b0;
      if (rvCnt > 0) begin
        rvCnt--;
        if (rvCnt == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= rdBuf;
        end
      end
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          memArr[mem_addr[7:0]] = mem_wdata;
        end else begin
          rdBuf = memArr[mem_addr[7:0]];
          if (rvLat == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= rdBuf;
          end else begin
            rvCnt = rvLat - 1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a ready pulse or a granted request appears.
  initial begin
    rdExp_t      e;
    reqExp_t     q;
    int          wc;
    logic        prevStall;
    logic [15:0] prevAddr;
    prevStall = 1'b0;
    prevAddr  = 16'd0;
    forever begin
      @(negedge clk);
      if (read_ready !== 64'd0) begin
        rdSeen++;
        checkOutput("read_ready_format", read_ready, 64'd1);
        if (rdExpQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL read_unexpected: pulse at cycle %0d with data 0x%0h, none expected", cyc, read_data);
        end else begin
          e = rdExpQ.pop_front();
          checkOutput("read_data", read_data, e.data);
          if (e.expCyc >= 0) checkOutput("read_latency", 64'(cyc), 64'(e.expCyc));
        end
      end
      if (write_ready !== 64'd0) begin
        wrSeen++;
        checkOutput("write_ready_format", write_ready, 64'd1);
        if (wrExpQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL write_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          wc = wrExpQ.pop_front();
          if (wc >= 0) checkOutput("write_latency", 64'(cyc), 64'(wc));
        end
      end
      if (mem_req && mem_gnt) begin
        if (reqExpQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL mem_unexpected: request we=%0b addr=0x%0h at cycle %0d, none expected", mem_we, mem_addr, cyc);
        end else begin
          q = reqExpQ.pop_front();
          checkOutput("mem_we", 64'(mem_we), 64'(q.we));
          checkOutput("mem_addr", 64'(mem_addr), 64'(q.addr));
          if (q.we) checkOutput("mem_wdata", mem_wdata, q.wdata);
        end
      end
      if (mem_req && !mem_gnt) begin
        stallCnt++;
        if (prevStall) checkOutput("stall_addr_stable", 64'(mem_addr), 64'(prevAddr));
      end
      prevStall = mem_req && !mem_gnt;
      prevAddr  = mem_addr;
    end
  end

  task automatic applyStimulus(input bit isWrite, input bit first, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] expData, input int latency);
    rdExp_t  re;
    reqExp_t rq;
    @(negedge clk);
    rq.we    = isWrite;
    rq.addr  = 16'(addr >> 3);
    rq.wdata = wdata;
    reqExpQ.push_back(rq);
    if (!isWrite) begin
      read_addr = addr;
      if (first) read_enable = 1'b1;
      else       finish_read = 1'b1;
      re.data   = expData;
      re.expCyc = (latency < 0) ? -1 : cyc + latency;
      rdExpQ.push_back(re);
    end else begin
      write_addr = addr;
      write_data = wdata;
      if (first) write_enable = 1'b1;
      else       finish_write = 1'b1;
      wrExpQ.push_back((latency < 0) ? -1 : cyc + latency);
    end
    @(negedge clk);
    finish_read  = 1'b0;
    finish_write = 1'b0;
  endtask

  task automatic waitDone(input int rdTarget, input int wrTarget, input string name);
    int n;
    n = 0;
    while ((rdSeen < rdTarget || wrSeen < wrTarget) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_read_pulses"}, 64'(rdSeen), 64'(rdTarget));
    checkOutput({name, "_write_pulses"}, 64'(wrSeen), 64'(wrTarget));
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] rdWords [0:3];
    reqExp_t     rq;
    rdExp_t      re;
    rdWords[0] = WORD_A;
    rdWords[1] = WORD_B;
    rdWords[2] = WORD_C;
    rdWords[3] = WORD_D;

    reset        = 1'b1;
    read_enable  = 1'b0;
    read_addr    = 64'd0;
    finish_read  = 1'b0;
    write_enable = 1'b0;
    write_addr   = 64'd0;
    write_data   = 64'd0;
    finish_write = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_read_ready", read_ready, 64'd0);
    checkOutput("reset_write_ready", write_ready, 64'd0);
    checkOutput("reset_read_data", read_data, 64'd0);
    checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 64'd0);
    checkOutput("reset_proto_err", 64'(proto_err), 64'd0);
    checkOutput("reset_rd_beats", 64'(rd_beats), 64'd0);
    checkOutput("reset_wr_beats", 64'(wr_beats), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 4-beat read from 0x100");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, i == 0, 64'h100 + 64'(8 * i), 64'd0, rdWords[i], 3);
      waitDone(i + 1, 0, "read4");
    end
    checkOutput("read4_rd_beats", 64'(rd_beats), 64'd4);
    repeat (3) @(negedge clk);
    checkOutput("read_data_hold", read_data, WORD_D);
    checkOutput("read4_proto_err", 64'(proto_err), 64'd0);

    $display("[TB] grant back-pressure");
    gntBlock = 1'b1;
    stallCnt = 0;
    applyStimulus(1'b0, 1'b0, 64'h120, 64'd0, WORD_E, 8);
    repeat (5) @(posedge clk);
    #1 gntBlock = 1'b0;
    waitDone(5, 0, "backpressure");
    checkOutput("stall_cycles", 64'(stallCnt), 64'd5);
    checkOutput("backpressure_rd_beats", 64'(rd_beats), 64'd5);

    $display("[TB] 3-beat write to 0x200");
    @(negedge clk);
    read_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, i == 0, 64'h200 + 64'(8 * i), 64'(i + 1), 64'd0, 2);
      waitDone(5, i + 1, "write3");
    end
    checkOutput("mem_word_0x40", memArr[8'h40], 64'd1);
    checkOutput("mem_word_0x41", memArr[8'h41], 64'd2);
    checkOutput("mem_word_0x42", memArr[8'h42], 64'd3);
    checkOutput("write3_wr_beats", 64'(wr_beats), 64'd3);
    checkOutput("write3_proto_err", 64'(proto_err), 64'd0);

    $display("[TB] simultaneous read and write pending");
    @(negedge clk);
    write_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    read_enable  = 1'b1;
    read_addr    = 64'h110;
    write_enable = 1'b1;
    write_addr   = 64'h218;
    write_data   = 64'h44;
    rq.we = 1'b0; rq.addr = 16'h22; rq.wdata = 64'd0;
    reqExpQ.push_back(rq);
    rq.we = 1'b1; rq.addr = 16'h43; rq.wdata = 64'h44;
    reqExpQ.push_back(rq);
    re.data = WORD_C; re.expCyc = cyc + 3;
    rdExpQ.push_back(re);
    wrExpQ.push_back(cyc + 6);
    waitDone(6, 4, "simultaneous");
    checkOutput("simul_proto_err", 64'(proto_err), 64'd1);
    checkOutput("mem_word_0x43", memArr[8'h43], 64'h44);
    checkOutput("simul_rd_beats", 64'(rd_beats), 64'd6);
    checkOutput("simul_wr_beats", 64'(wr_beats), 64'd4);

    @(negedge clk);
    reset        = 1'b1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    @(negedge clk);
    checkOutput("rst2_proto_err", 64'(proto_err), 64'd0);
    checkOutput("rst2_rd_beats", 64'(rd_beats), 64'd0);
    checkOutput("rst2_wr_beats", 64'(wr_beats), 64'd0);
    checkOutput("rst2_read_data", read_data, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] extra finish_read during RD_WAIT");
    rvLat = 3;
    @(negedge clk);
    read_enable = 1'b1;
    read_addr   = 64'h100;
    rq.we = 1'b0; rq.addr = 16'h20; rq.wdata = 64'd0;
    reqExpQ.push_back(rq);
    re.data = WORD_A; re.expCyc = cyc + 5;
    rdExpQ.push_back(re);
    @(negedge clk);
    @(negedge clk);
    finish_read = 1'b1;
    read_addr   = 64'h108;
    @(negedge clk);
    finish_read = 1'b0;
    waitDone(7, 4, "extra_finish");
    repeat (4) @(negedge clk);
    checkOutput("extra_finish_proto_err", 64'(proto_err), 64'd1);
    checkOutput("extra_finish_rd_beats", 64'(rd_beats), 64'd1);
    checkOutput("extra_finish_no_req", 64'(reqExpQ.size()), 64'd0);

    $display("[TB] reset during RD_WAIT");
    @(negedge clk);
    read_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    read_enable = 1'b1;
    read_addr   = 64'h118;
    rq.we = 1'b0; rq.addr = 16'h23; rq.wdata = 64'd0;
    reqExpQ.push_back(rq);
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    read_enable = 1'b0;
    #1;
    checkOutput("midrst_read_ready", read_ready, 64'd0);
    checkOutput("midrst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("midrst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("midrst_read_data", read_data, 64'd0);
    checkOutput("midrst_proto_err", 64'(proto_err), 64'd0);
    checkOutput("midrst_rd_beats", 64'(rd_beats), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("late_rvalid_read_data", read_data, 64'd0);
    checkOutput("late_rvalid_rd_beats", 64'(rd_beats), 64'd0);
    checkOutput("late_rvalid_read_pulses", 64'(rdSeen), 64'd7);

    checkOutput("read_queue_drained", 64'(rdExpQ.size()), 64'd0);
    checkOutput("write_queue_drained", 64'(wrExpQ.size()), 64'd0);
    checkOutput("req_queue_drained", 64'(reqExpQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
